// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared op codes, state encoding and sign-flag helpers for the multiply sequencer
package mul_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        MUL_OP_LO  = 2'b00,
        MUL_OP_HSS = 2'b01,
        MUL_OP_HSU = 2'b10,
        MUL_OP_HUU = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mul_state_e;

    // rs1 is treated as signed for MULH and MULHSU
    function automatic logic op_rs1_signed(input mul_op_e op);
        return (op == MUL_OP_HSS) || (op == MUL_OP_HSU);
    endfunction

    // rs2 is treated as signed only for MULH
    function automatic logic op_rs2_signed(input mul_op_e op);
        return (op == MUL_OP_HSS);
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - issue/result bundle between execute stage and multiply sequencer
interface mul_sequencer_if
    import mul_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic              start_i;
    mul_op_e           op_i;
    logic [XLEN-1:0]   rs1_i;
    logic [XLEN-1:0]   rs2_i;
    logic              flush_i;
    logic              busy_o;
    logic              stall_o;
    logic              done_o;
    logic [2*XLEN-1:0] product_o;
    logic [XLEN-1:0]   result_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, flush_i,
        input  busy_o, stall_o, done_o, product_o, result_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, flush_i,
        output busy_o, stall_o, done_o, product_o, result_o
    );
endinterface

// File: rtl/mul_iter_datapath.sv
// rtl/mul_iter_datapath.sv - operand/accumulator registers, shift-add step and final sign fix
module mul_iter_datapath #(
    parameter int XLEN = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              fix_i,
    input  logic              neg1_i,
    input  logic              neg2_i,
    input  logic              hi_sel_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    output logic [2*XLEN-1:0] product_o,
    output logic [XLEN-1:0]   result_o
);

    // Multiplicand is kept pre-shifted so each step adds it directly; the
    // multiplier shifts right so bit 0 is always the bit being processed.
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [2*XLEN-1:0] acc_q;
    logic              neg_q;
    logic [2*XLEN-1:0] product_q;
    logic [XLEN-1:0]   result_q;

    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [2*XLEN-1:0] fixed_prod;

    // Magnitudes at load time; the most negative value maps onto itself, which
    // is the correct unsigned magnitude 2^(XLEN-1)
    always_comb begin
        mag1       = neg1_i ? (~rs1_i + 1'b1) : rs1_i;
        mag2       = neg2_i ? (~rs2_i + 1'b1) : rs2_i;
        fixed_prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    end

    // Operand load, one shift-add per step, and product/result capture on fix
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            result_q  <= '0;
        end else begin
            if (load_i) begin
                mcand_q  <= {{XLEN{1'b0}}, mag1};
                mplier_q <= mag2;
                acc_q    <= '0;
                neg_q    <= neg1_i ^ neg2_i;
            end else if (step_i) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= {mcand_q[2*XLEN-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
            end
            // Result is captured alongside the product so a later flushed op
            // with a different op code cannot disturb the held writeback word
            if (fix_i) begin
                product_q <= fixed_prod;
                result_q  <= hi_sel_i ? fixed_prod[2*XLEN-1:XLEN] : fixed_prod[XLEN-1:0];
            end
        end
    end

    assign product_o = product_q;
    assign result_o  = result_q;

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative radix-2 RV32M multiply controller with pipeline stall
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input logic           clock,
    input logic           reset,
    mul_sequencer_if.slave bus
);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mul_op_e          op_q;

    logic accept;
    logic last_iter;
    logic load, step, fix;
    logic neg1, neg2;

    assign accept    = (state_q == ST_IDLE) && bus.start_i && !bus.flush_i;
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));
    assign neg1      = bus.rs1_i[XLEN-1] && op_rs1_signed(bus.op_i);
    assign neg2      = bus.rs2_i[XLEN-1] && op_rs2_signed(bus.op_i);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: flush aborts RUN/FIX but a finished op in DONE still retires
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)                 state_d = ST_RUN;
            ST_RUN:  if (bus.flush_i)            state_d = ST_IDLE;
                     else if (last_iter)         state_d = ST_FIX;
            ST_FIX:  if (bus.flush_i)            state_d = ST_IDLE;
                     else                        state_d = ST_DONE;
            ST_DONE:                             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath strobes decoded from the current state
    always_comb begin
        load        = accept;
        step        = (state_q == ST_RUN) && !bus.flush_i;
        fix         = (state_q == ST_FIX) && !bus.flush_i;
        bus.busy_o  = (state_q != ST_IDLE);
        bus.done_o  = (state_q == ST_DONE);
        bus.stall_o = accept || (state_q == ST_RUN) || (state_q == ST_FIX);
    end

    // Iteration counter and latched op code
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            op_q  <= MUL_OP_LO;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                op_q <= bus.op_i;
            end
        end
    end

    // Counter restarts on accept and advances once per processed multiplier bit
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    mul_iter_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clock     (clock),
        .reset     (reset),
        .load_i    (load),
        .step_i    (step),
        .fix_i     (fix),
        .neg1_i    (neg1),
        .neg2_i    (neg2),
        .hi_sel_i  (op_q != MUL_OP_LO),
        .rs1_i     (bus.rs1_i),
        .rs2_i     (bus.rs2_i),
        .product_o (bus.product_o),
        .result_o  (bus.result_o)
    );

endmodule
